// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data access.
// Data wins over fetch; each access runs grant -> busy (until ack) -> one response cycle.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_sel,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    output logic        ram_ce,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_sel,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ack,
    output logic        stall_if,
    output logic        stall_mem
);

    typedef enum logic [1:0] {StIdle, StIfBusy, StMemBusy, StResp} state_e;

    state_e state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            ram_ce    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= 32'h0;
            ram_wdata <= 32'h0;
            ram_sel   <= 4'h0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            if_rdata  <= 32'h0;
            mem_rdata <= 32'h0;
        end else begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (mem_req) begin
                        state     <= StMemBusy;
                        ram_ce    <= 1'b1;
                        ram_we    <= mem_we;
                        ram_addr  <= mem_addr;
                        ram_wdata <= mem_wdata;
                        ram_sel   <= mem_sel;
                    end else if (if_req) begin
                        state     <= StIfBusy;
                        ram_ce    <= 1'b1;
                        ram_we    <= 1'b0;
                        ram_addr  <= if_addr;
                        ram_wdata <= 32'h0;
                        ram_sel   <= 4'b1111;
                    end
                end
                StIfBusy, StMemBusy: begin
                    if (ram_ack) begin
                        state  <= StResp;
                        ram_ce <= 1'b0;
                        ram_we <= 1'b0;
                        if (state == StMemBusy) begin
                            // ram_we still holds the granted direction here
                            mem_rdata <= ram_we ? 32'h0 : ram_rdata;
                            mem_done  <= 1'b1;
                        end else begin
                            if_rdata <= ram_rdata;
                            if_done  <= 1'b1;
                        end
                    end
                end
                StResp: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign stall_if  = if_req & ~if_done;
    assign stall_mem = mem_req & ~mem_done;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with all state sampled on the rising edge of clk.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  instruction-fetch read request
- if_addr  in  32  fetch address
- if_done  out  1  one-cycle fetch completion pulse
- if_rdata  out  32  fetched word, valid while if_done=1
- mem_req  in  1  data-access request
- mem_we  in  1  1=write, 0=read
- mem_addr  in  32  data address
- mem_wdata  in  32  store data
- mem_sel  in  4  byte enables
- mem_done  out  1  one-cycle data completion pulse
- mem_rdata  out  32  load data, valid while mem_done=1
- ram_ce  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  32  RAM address
- ram_wdata  out  32  RAM write data
- ram_sel  out  4  RAM byte enables
- ram_rdata  in  32  RAM read data, valid with ram_ack
- ram_ack  in  1  RAM completion, one cycle
- stall_if  out  1  fetch stage must hold PC
- stall_mem  out  1  memory stage must hold

Function
REQ-003 The block SHALL share the single RAM port between the fetch and data requesters using an FSM with states IDLE, IF_BUSY, MEM_BUSY and RESP.
REQ-004 In IDLE with mem_req=1, the next state SHALL be MEM_BUSY; otherwise, with if_req=1, IF_BUSY; otherwise IDLE (fixed priority: data over fetch).
REQ-005 On the grant edge, ram_ce, ram_we, ram_addr, ram_wdata and ram_sel SHALL be registered from the winner's inputs (fetch: ram_we=0, ram_sel=4'b1111, ram_wdata=0).
REQ-006 ram_* outputs SHALL stay constant throughout a BUSY state regardless of changes on the requester inputs.
REQ-007 In a BUSY state with ram_ack=1, the next state SHALL be RESP, ram_ce and ram_we SHALL go 0, and ram_rdata SHALL be latched into the owner's rdata register.
REQ-008 In RESP, exactly the owner's done output SHALL be 1 for one cycle, with the corresponding rdata valid, and the next state SHALL be IDLE unconditionally; no grant is made in RESP.
REQ-009 For a write, mem_rdata in RESP SHALL be 32'h0.
REQ-010 Latency SHALL be as follows: request seen at edge N, ram_ce=1 during cycle N+1, ack in cycle M, done during cycle M+1, IDLE at M+2; the minimum access is 3 cycles when ram_ack arrives in the first BUSY cycle.
REQ-011 The if_rdata and mem_rdata registers SHALL hold their last value outside RESP.
REQ-012 ram_ack SHALL be ignored in IDLE and RESP.
REQ-013 A requester whose req drops mid-transaction SHALL NOT abort it: the RAM access completes and the done pulse is still issued.
REQ-014 stall_if SHALL equal if_req & ~if_done, and stall_mem SHALL equal mem_req & ~mem_done; both are combinational.
REQ-015 When both requests are continuously asserted, accesses SHALL strictly alternate only as requesters drop and re-raise req; fetch is served only in an IDLE cycle where mem_req=0.
REQ-016 Wait states SHALL be unbounded; the block SHALL wait in BUSY indefinitely until ram_ack.

Reset
REQ-017 While rst=1 at a clock edge, the state SHALL become IDLE and all outputs SHALL be 0 on the next cycle (ram_*, if_done, mem_done, if_rdata, mem_rdata), with stall_* following REQ-014.
REQ-018 Reset asserted during BUSY or RESP SHALL abandon the transaction: no done pulse is issued, and a ram_ack in the reset cycle is ignored.
REQ-019 After rst deasserts, the first grant SHALL occur at the first edge in IDLE with a request pending.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Fetch only: if_req=1, if_addr=0x100, ack 2 cycles after ram_ce with ram_rdata=0xDEADBEEF -> ram_addr=0x100, ram_we=0; if_done pulses once with if_rdata=0xDEADBEEF; stall_if=1 until that cycle.
- Simultaneous requests: if_req=1 (0x200) and mem_req=1 read (0x8000) in the same IDLE cycle, immediate acks -> MEM served first (ram_addr=0x8000, mem_done); fetch granted after RESP→IDLE; if_done 3 cycles after mem_done.
- Store: mem_we=1, addr=0x40, wdata=0x12345678, sel=4'b0011 -> RAM sees identical values for the whole BUSY state; mem_done with mem_rdata=0.
- Input change mid-access: if_addr changes 0x100→0x104 during IF_BUSY -> ram_addr stays 0x100 until ack.
- Reset mid-access: rst=1 in MEM_BUSY with ram_ack=1 in the same cycle -> no mem_done, ram_ce=0, state IDLE next cycle.
- Back-to-back fetches: if_req held high through if_done -> the second ram_ce appears 2 cycles after if_done (IDLE then grant), no double-issue during RESP.
